// File: rtl/muldiv_seq_pkg.sv
// muldiv_seq_pkg: op and state encodings shared by the mul/div sequencer and its sign-fix helper.
package muldiv_seq_pkg;
  typedef enum logic [2:0] {
    MD_MUL   = 3'd0,
    MD_MULH  = 3'd1,
    MD_MULHU = 3'd3,
    MD_DIV   = 3'd4,
    MD_DIVU  = 3'd5,
    MD_REM   = 3'd6,
    MD_REMU  = 3'd7
  } md_op_t;
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} md_state_t;
  localparam int MD_WIDTH = 64;
  localparam int MD_CNT_W = $clog2(MD_WIDTH);
  function automatic logic md_is_div(input md_op_t o);
    return o[2];
  endfunction
  function automatic logic md_is_rem(input md_op_t o);
    return o inside {MD_REM, MD_REMU};
  endfunction
  function automatic logic md_is_signed(input md_op_t o);
    return o inside {MD_MULH, MD_DIV, MD_REM};
  endfunction
endpackage

// File: rtl/muldiv_seq_signfix.sv
// md_signfix: absolute operands for signed ops and sign correction of a raw result.
module md_signfix
  import muldiv_seq_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic [2:0]         op_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  input  logic [2*WIDTH-1:0] r_i,
  output logic [WIDTH-1:0]   a_o,
  output logic [WIDTH-1:0]   b_o,
  output logic [2*WIDTH-1:0] r_o
);
  md_op_t op;
  logic sa, sb, neg;
  assign op  = md_op_t'(op_i);
  assign sa  = md_is_signed(op) & a_i[WIDTH-1];
  assign sb  = md_is_signed(op) & b_i[WIDTH-1];
  // remainder follows the dividend, everything else the product/quotient sign
  assign neg = md_is_rem(op) ? sa : sa ^ sb;
  assign a_o = sa ? -a_i : a_i;
  assign b_o = sb ? -b_i : b_i;
  assign r_o = neg ? -r_i : r_i;
endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative shift-add multiplier / restoring divider with execute stall.
// Define MULDIV_FASTPATH_EN to retire divide-by-zero, signed overflow and zero-operand multiplies in one cycle.
module muldiv_seq
  import muldiv_seq_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic             flush,
  output logic             stall,
  output logic [WIDTH-1:0] result,
  output logic             result_valid
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_V = {1'b1, {(WIDTH-1){1'b0}}};
`ifdef MULDIV_FASTPATH_EN
  localparam logic FAST = 1'b1;
`else
  localparam logic FAST = 1'b0;
`endif
  md_state_t state_q, state_d;
  md_op_t op_in, op_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, b_q, y_q, result_q, result_d;
  logic [WIDTH-1:0] abs_a, abs_b, unused_a, unused_b, spec_val;
  logic [2*WIDTH-1:0] prod_q, prod_d, raw, fixed, unused_r;
  logic [WIDTH:0] mul_sum, div_sh, div_diff, spec;
  logic load, spec_hit;
  // returns {hit, value} for results that bypass the iterative core
  function automatic logic [WIDTH:0] special(input md_op_t o, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic quo;
    quo = o inside {MD_DIV, MD_DIVU};
    if (md_is_div(o) && b == '0)
      return {1'b1, quo ? {WIDTH{1'b1}} : a};
    if (md_is_signed(o) && md_is_div(o) && a == MIN_V && b == {WIDTH{1'b1}})
      return {1'b1, quo ? MIN_V : {WIDTH{1'b0}}};
    if (!md_is_div(o) && (a == '0 || b == '0))
      return {1'b1, {WIDTH{1'b0}}};
    return '0;
  endfunction
  assign op_in = md_op_t'(op);
  md_signfix #(.WIDTH(WIDTH)) u_in (
    .op_i(op), .a_i(srca), .b_i(srcb), .r_i('0),
    .a_o(abs_a), .b_o(abs_b), .r_o(unused_r)
  );
  md_signfix #(.WIDTH(WIDTH)) u_out (
    .op_i(op_q), .a_i(a_q), .b_i(b_q), .r_i(raw),
    .a_o(unused_a), .b_o(unused_b), .r_o(fixed)
  );
  assign spec     = (state_q == IDLE) ? special(op_in, srca, srcb) : special(op_q, a_q, b_q);
  assign spec_hit = spec[WIDTH];
  assign spec_val = spec[WIDTH-1:0];
  assign mul_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, y_q} : '0);
  assign div_sh   = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]};
  assign div_diff = div_sh - {1'b0, y_q};
  // prod holds {product} for multiplies and {remainder, quotient} for divides
  assign raw      = md_is_div(op_q) ? {{WIDTH{1'b0}}, md_is_rem(op_q) ? prod_d[2*WIDTH-1:WIDTH] : prod_d[WIDTH-1:0]} : prod_d;
  assign result_d = spec_hit ? spec_val : (op_q inside {MD_MULH, MD_MULHU}) ? fixed[2*WIDTH-1:WIDTH] : fixed[WIDTH-1:0];
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    load    = 1'b0;
    case (state_q)
      IDLE: if (in_valid && !flush) begin
        load    = 1'b1;
        cnt_d   = '0;
        prod_d  = {{WIDTH{1'b0}}, abs_a};
        state_d = FAST && spec_hit ? DONE : md_is_div(op_in) ? DIV : MUL;
      end
      MUL: begin
        prod_d  = {mul_sum, prod_q[WIDTH-1:1]};
        cnt_d   = cnt_q + CW'(1);
        state_d = (cnt_q == CW'(WIDTH-1)) ? DONE : MUL;
      end
      DIV: begin
        prod_d  = {div_diff[WIDTH] ? div_sh[WIDTH-1:0] : div_diff[WIDTH-1:0], prod_q[WIDTH-2:0], !div_diff[WIDTH]};
        cnt_d   = cnt_q + CW'(1);
        state_d = (cnt_q == CW'(WIDTH-1)) ? DONE : DIV;
      end
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= MD_MUL;
      a_q      <= '0;
      b_q      <= '0;
      y_q      <= '0;
      prod_q   <= '0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
      if (load) begin
        op_q <= op_in;
        a_q  <= srca;
        b_q  <= srcb;
        y_q  <= abs_b;
      end
      if (state_d == DONE && state_q != DONE) result_q <= result_d;
    end
  end
  assign stall        = resetn & in_valid & (state_q != DONE) & !flush;
  assign result       = result_q;
  assign result_valid = (state_q == DONE) & !flush;
endmodule
